// File: rtl/keypad_scan_fifo.sv
// Keypad matrix scanner: column drive, whole-scan debounce with ghost rejection, key-code FIFO.
// Define KEYPAD_ASCII_MAP_EN (4x4 only) to emit ASCII legends instead of index+1 codes.
module keypad_scan_fifo #(
  parameter int NUM_COLS       = 4,
  parameter int NUM_ROWS       = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [NUM_COLS-1:0] cols,
  input  logic [NUM_ROWS-1:0] rows,
  output logic [7:0]          out,
  output logic                key_ready,
  input  logic                key_read,
  output logic                overflow
);

  localparam int NK = NUM_ROWS * NUM_COLS;
  localparam int DW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(NUM_COLS - 1);
  localparam logic [3:0]    DEB_N      = 4'(DEBOUNCE_SCANS);
  localparam logic [PW:0]   FULL_N     = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

  function automatic logic [7:0] key_code(input logic [7:0] k);
`ifdef KEYPAD_ASCII_MAP_EN
    case (k)
      8'd0:    key_code = 8'd49;  // '1'
      8'd1:    key_code = 8'd50;  // '2'
      8'd2:    key_code = 8'd51;  // '3'
      8'd3:    key_code = 8'd65;  // 'A'
      8'd4:    key_code = 8'd52;  // '4'
      8'd5:    key_code = 8'd53;  // '5'
      8'd6:    key_code = 8'd54;  // '6'
      8'd7:    key_code = 8'd66;  // 'B'
      8'd8:    key_code = 8'd55;  // '7'
      8'd9:    key_code = 8'd56;  // '8'
      8'd10:   key_code = 8'd57;  // '9'
      8'd11:   key_code = 8'd67;  // 'C'
      8'd12:   key_code = 8'd42;  // '*'
      8'd13:   key_code = 8'd48;  // '0'
      8'd14:   key_code = 8'd35;  // '#'
      8'd15:   key_code = 8'd68;  // 'D'
      default: key_code = 8'd0;
    endcase
`else
    key_code = k + 8'd1;
`endif
  endfunction

  // p0/p1: two-flop synchroniser for the asynchronous row inputs
  logic [NUM_ROWS-1:0] rows_p0, rows_p1;

  always_ff @(posedge clk) begin
    rows_p0 <= rows;
    rows_p1 <= rows_p0;
  end

  logic [DW-1:0] dwell;
  logic [CW-1:0] col;
  logic          last_dwell;

  assign last_dwell = (dwell == DWELL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
      col   <= '0;
    end else if (last_dwell) begin
      dwell <= '0;
      col   <= (col == COL_LAST) ? '0 : col + 1'b1;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  // Column 0 drives the MSB; shift the one-hot right as the index advances.
  assign cols = {1'b1, {(NUM_COLS-1){1'b0}}} >> col;

  // p2: full-scan snapshot, vld_p2 pulses once the last column has been captured
  logic [NK-1:0] snap_p2;
  logic          vld_p2;

  always_ff @(posedge clk) begin
    if (last_dwell) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        snap_p2[r*NUM_COLS + int'(col)] <= rows_p1[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p2 <= 1'b0;
    else        vld_p2 <= last_dwell && (col == COL_LAST);
  end

  logic       any_key, multi_key, one_key;
  logic [7:0] key_idx;

  always_comb begin
    any_key   = 1'b0;
    multi_key = 1'b0;
    key_idx   = '0;
    for (int i = 0; i < NK; i++) begin
      if (snap_p2[i]) begin
        if (any_key) multi_key = 1'b1;
        any_key = 1'b1;
        key_idx = 8'(i);
      end
    end
  end

  assign one_key = any_key && !multi_key;

  state_t     state, state_nxt;
  logic [7:0] cand, cand_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    push      = 1'b0;
    if (vld_p2) begin
      case (state)
        IDLE: begin
          if (one_key) begin
            cand_nxt = key_idx;
            cnt_nxt  = 4'd1;
            if (DEB_N == 4'd1) begin
              push      = 1'b1;
              state_nxt = HELD;
            end else begin
              state_nxt = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (one_key && key_idx == cand) begin
            cnt_nxt = cnt + 4'd1;
            if (cnt + 4'd1 == DEB_N) begin
              push      = 1'b1;
              state_nxt = HELD;
            end
          end else if (one_key) begin
            cand_nxt = key_idx;
            cnt_nxt  = 4'd1;
          end else begin
            state_nxt = IDLE;
          end
        end
        HELD: begin
          if (!any_key) begin
            cnt_nxt   = 4'd1;
            state_nxt = (DEB_N == 4'd1) ? IDLE : RELEASE_CHK;
          end
        end
        RELEASE_CHK: begin
          if (!any_key) begin
            cnt_nxt = cnt + 4'd1;
            if (cnt + 4'd1 == DEB_N) state_nxt = IDLE;
          end else begin
            state_nxt = HELD;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fill;
  logic          pop, full, wr_en, drop;

  assign pop   = key_read && (fill != '0);
  assign full  = (fill == FULL_N);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= key_code(key_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      if (drop)                                     overflow <= 1'b1;
      else if (pop && !wr_en && fill == (PW+1)'(1)) overflow <= 1'b0;
    end
  end

  assign key_ready = (fill != '0);
  assign out       = key_ready ? mem[rd_ptr] : 8'd0;

endmodule

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
- Parametrised successor to the single-register keypad scanner: scans an NUM_ROWS x NUM_COLS matrix with per-column settle time.
- Debounces across whole scans and rejects multi-key ghosting.
- Emits one code per press, none on hold; buffers codes in a FIFO behind the existing key_ready/key_read handshake.
- Sits between the board keypad pins and the CPU peripheral bus.

Parameters:
NUM_COLS, 4, number of driven column lines (2..8)
NUM_ROWS, 4, number of sensed row lines (2..8)
SETTLE_CYCLES, 16, clk cycles each column is driven before rows are sampled (>=4)
DEBOUNCE_SCANS, 3, consecutive identical full scans needed to accept a press or release (1..15)
FIFO_DEPTH, 4, key codes buffered (power of two, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cols  output  NUM_COLS  one-hot active-high column drive
rows  input  NUM_ROWS  raw row sense, active-high, asynchronous to clk
out  output  8  key code at FIFO head, 0 when empty
key_ready  output  1  FIFO non-empty
key_read  input  1  single-cycle pop strobe from the host
overflow  output  1  sticky: a code was dropped because the FIFO was full

Behaviour:
- Reset (async, rst_n=0): cols = one-hot MSB (column 0); out=0, key_ready=0, overflow=0; FIFO empty; dwell counter, debounce counter and state cleared. Takes effect immediately, including mid-scan or mid-debounce; any partial press is discarded.
- Synchroniser: rows pass through a 2-flop synchroniser before any use.
- Scan: column index c drives cols[NUM_COLS-1-c]. Each column is held SETTLE_CYCLES cycles.
  - Synchronised rows are sampled on the last dwell cycle into a NUM_ROWS x NUM_COLS snapshot.
  - Then advance c; wrap NUM_COLS-1 -> 0. Scan period = NUM_COLS*SETTLE_CYCLES.
- Scan classification, evaluated once per completed scan: NONE (0 keys set), ONE (exactly 1 set; index k = row*NUM_COLS + col), MULTI (>=2 set).
- Debounce FSM, states IDLE, PRESS_CHK, HELD, RELEASE_CHK:
  - IDLE: ONE -> PRESS_CHK, cand=k, cnt=1; NONE/MULTI -> stay.
  - PRESS_CHK: ONE with same k -> cnt++. When cnt reaches DEBOUNCE_SCANS: push code(cand), go HELD. ONE with different k -> restart with new cand, cnt=1. NONE/MULTI -> IDLE.
  - HELD: no further pushes while any key is down. NONE -> RELEASE_CHK, cnt=1.
  - RELEASE_CHK: NONE -> cnt++; cnt==DEBOUNCE_SCANS -> IDLE. Anything else -> HELD.
  - DEBOUNCE_SCANS=1: a single ONE scan pushes immediately, and a single NONE scan returns to IDLE.
- Code: code(k) = k+1 (8-bit). 0 is reserved for "no key".
- Latency: push happens on the clk after the final column sample of the accepting scan. out/key_ready update on the following clk.
- FIFO/handshake:
  - out always shows the head entry; key_ready = !empty.
  - key_read with key_ready=1 pops one entry; out/key_ready update next cycle. key_read while empty is ignored.
  - Push while full: code dropped, overflow set. Simultaneous push and pop while full: both happen, nothing dropped, overflow unchanged.
  - overflow clears only on reset, or on a pop that leaves the FIFO empty.
- Pointers wrap modulo FIFO_DEPTH. An occupancy counter of width log2(FIFO_DEPTH)+1 distinguishes full from empty.

Optional Feature:
- Macro: KEYPAD_ASCII_MAP_EN.
- Defined (only legal with NUM_ROWS=4, NUM_COLS=4): code(k) is ASCII:
  - col0: 1 4 7 *
  - col1: 2 5 8 0
  - col2: 3 6 9 #
  - col3: A B C D
  - e.g. row1 col2 -> 8'd54.
- Undefined: code(k)=k+1.
- All timing and handshake behaviour is identical in both builds.

Test Plan:
Bench config for all scenarios: 4x4, SETTLE_CYCLES=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4, macro off (scan period 16 clk).
- Reset/scan: hold rst_n=0, release -> cols=4'b1000, then 4'b0100 after 4 clk, 4'b0010, 4'b0001, back to 4'b1000 at clk 16; out=0, key_ready=0.
- Single press: hold rows[1] only while col2 driven, for 3 scans -> exactly one push, out=8'd7 (k=6), key_ready=1. Still held 5 more scans -> no second push. key_read pulse -> key_ready=0, out=0 next cycle.
- Bounce/ghost: press lasting 1 scan -> no push. Two keys (k=0 and k=5) down for 4 scans -> no push. Release one key, hold k=5 for 2 scans -> push 8'd6.
- Overflow: 5 distinct debounced press/release cycles, no reads -> FIFO holds codes 1..4 in order, 5th dropped, overflow=1. 4 reads return 1,2,3,4; overflow clears on the pop that empties the FIFO.
- Simultaneous: FIFO full, key_read asserted on the push cycle -> occupancy stays 4, overflow stays 0. Assert rst_n=0 mid-PRESS_CHK -> all outputs at reset values within the same cycle, no push after release.
- Macro on: debounced press at row3 col0 -> out=8'd42 ('*'); row0 col3 -> out=8'd65 ('A').
